// File: rtl/cpu_perf_pkg.sv
// Shared definitions for the CPU performance-counter bank.
// Holds the conventional channel assignment used by the pipeline wiring,
// the default counter width and the encoding of the read-source select.
package cpu_perf_pkg;

  // Conventional channel assignment for the pipelined CPU.
  localparam int unsigned CH_TOTAL    = 0;  // every running cycle
  localparam int unsigned CH_BUBBLE   = 1;  // pipeline bubbles
  localparam int unsigned CH_CONDBR   = 2;  // conditional branches
  localparam int unsigned CH_UNCONDBR = 3;  // unconditional branches

  localparam int unsigned DEFAULT_WIDTH = 32;

  // rd_src encoding: live counter or snapshot register.
  typedef enum logic {
    RD_LIVE = 1'b0,
    RD_SNAP = 1'b1
  } rd_src_e;

endpackage

// File: rtl/perf_counter_ch.sv
// Single performance-counter channel.
// Qualifies its event strobe (level or rising edge), counts qualified
// cycles with wrap or saturate on overflow, keeps a sticky overflow flag
// and a snapshot register.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   count_en   global count enable
//   freeze     holds the counter; edge history still tracks event_in
//   event_in   event strobe for this channel
//   clear      zeroes counter and overflow flag (wins over increment)
//   snap       copies the pre-update counter into snap_val
//   cnt        live counter value
//   snap_val   snapshot register
//   ovf        sticky overflow flag
module perf_counter_ch
  import cpu_perf_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter bit          EDGE     = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             freeze,
  input  logic             event_in,
  input  logic             clear,
  input  logic             snap,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] snap_val,
  output logic             ovf
);

  logic ev_d;
  logic qual;
  logic inc;
  logic at_max;

  always_comb begin
    qual   = EDGE ? (event_in & ~ev_d) : event_in;
    inc    = count_en & ~freeze & qual;
    at_max = &cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      snap_val <= '0;
      ovf      <= 1'b0;
      ev_d     <= 1'b0;
    end else begin
      // Edge history follows the raw input even while frozen, so releasing
      // freeze with the event held high does not look like a new edge.
      ev_d <= event_in;
      if (snap) begin
        snap_val <= cnt;
      end
      if (clear) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (inc) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (!SATURATE) begin
            cnt <= '0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Parametrised performance-counter bank for the pipelined CPU.
// N_CH independent channels (perf_counter_ch) plus a registered read port
// that returns either the live counter or its snapshot.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   count_en    global count enable (CPU running)
//   freeze      holds all counters; edge history still updates
//   event_in    per-channel event strobes
//   clear       zeroes live counters and overflow flags
//   snap        copies live counters into snapshot registers
//   rd_req      one-cycle read request
//   rd_sel      channel index to read
//   rd_src      0 = live counter, 1 = snapshot
//   rd_data     registered read data (holds when idle)
//   rd_valid    one-cycle pulse qualifying rd_data
//   rd_err      one-cycle pulse for an out-of-range rd_sel
//   ovf         sticky per-channel overflow flags
//   snap_valid  set once any snapshot has been taken
module pipeline_perf_monitor
  import cpu_perf_pkg::*;
#(
  parameter int unsigned       N_CH      = 4,
  parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
  parameter logic [N_CH-1:0]   EDGE_MASK = '0,
  parameter int unsigned       SATURATE  = 0,
  parameter int unsigned       SEL_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic              freeze,
  input  logic [N_CH-1:0]   event_in,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_src,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [N_CH-1:0]   ovf,
  output logic              snap_valid
);

  logic [WIDTH-1:0] cnt_arr  [N_CH];
  logic [WIDTH-1:0] snap_arr [N_CH];
  logic [WIDTH-1:0] live_sel;
  logic [WIDTH-1:0] snap_sel;
  logic             sel_ok;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      perf_counter_ch #(
        .WIDTH    (WIDTH),
        .EDGE     (EDGE_MASK[g]),
        .SATURATE (SATURATE != 0)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .freeze   (freeze),
        .event_in (event_in[g]),
        .clear    (clear),
        .snap     (snap),
        .cnt      (cnt_arr[g]),
        .snap_val (snap_arr[g]),
        .ovf      (ovf[g])
      );
    end
  endgenerate

  // Compare-based mux: rd_sel may address beyond N_CH, so no direct indexing.
  always_comb begin
    live_sel = '0;
    snap_sel = '0;
    sel_ok   = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(rd_sel) == i) begin
        live_sel = cnt_arr[i];
        snap_sel = snap_arr[i];
        sel_ok   = 1'b1;
      end
    end
  end

  // Read port samples pre-update values at the request edge, so a read
  // coincident with clear or snap returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      if (rd_req) begin
        if (sel_ok) begin
          rd_valid <= 1'b1;
          rd_data  <= (rd_src_e'(rd_src) == RD_SNAP) ? snap_sel : live_sel;
        end else begin
          rd_err  <= 1'b1;
          rd_data <= '0;
        end
      end
      if (snap) begin
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: two instances (wrap with edge channel 1,
// saturate with edge channels 1 and 3) share one stimulus stream.
module tb_pipeline_perf_monitor;
  import cpu_perf_pkg::*;

  localparam int NC   = 4;
  localparam int MAXV = 255;  // WIDTH = 8

  logic       clk = 1'b0;
  logic       rst, count_en, freeze, clear, snap, rd_req, rd_src;
  logic [3:0] event_in, rd_sel;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, rd_err0, rd_err1, snap_valid0, snap_valid1;
  logic [3:0] ovf0, ovf1;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(
    .N_CH(4), .WIDTH(8), .EDGE_MASK(4'b0010), .SATURATE(0), .SEL_W(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .count_en(count_en), .freeze(freeze),
    .event_in(event_in), .clear(clear), .snap(snap), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .rd_err(rd_err0), .ovf(ovf0),
    .snap_valid(snap_valid0)
  );

  pipeline_perf_monitor #(
    .N_CH(4), .WIDTH(8), .EDGE_MASK(4'b1010), .SATURATE(1), .SEL_W(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .count_en(count_en), .freeze(freeze),
    .event_in(event_in), .clear(clear), .snap(snap), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_err(rd_err1), .ovf(ovf1),
    .snap_valid(snap_valid1)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt  [2][NC];
  int m_snap [2][NC];
  bit m_ovf  [2][NC];
  bit m_prev [2][NC];   // last observed event level per channel
  int m_rd_data [2];
  bit m_rd_valid[2];
  bit m_rd_err  [2];
  bit m_snapv   [2];

  function automatic bit is_edge(int d, int ch);
    return (ch == 1) || (d == 1 && ch == 3);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int i = 0; i < NC; i++) begin
            m_cnt[d][i] = 0; m_snap[d][i] = 0; m_ovf[d][i] = 0; m_prev[d][i] = 0;
          end
          m_rd_data[d] = 0; m_rd_valid[d] = 0; m_rd_err[d] = 0; m_snapv[d] = 0;
        end else begin
          int sel;
          sel = int'(rd_sel);
          m_rd_valid[d] = 0;
          m_rd_err[d]   = 0;
          if (rd_req) begin
            if (sel >= NC) begin
              m_rd_err[d] = 1; m_rd_data[d] = 0;
            end else begin
              m_rd_valid[d] = 1;
              m_rd_data[d]  = rd_src ? m_snap[d][sel] : m_cnt[d][sel];
            end
          end
          if (snap) begin
            m_snapv[d] = 1;
            for (int i = 0; i < NC; i++) m_snap[d][i] = m_cnt[d][i];
          end
          for (int i = 0; i < NC; i++) begin
            bit counts;
            counts = count_en && !freeze &&
                     (is_edge(d, i) ? (event_in[i] && !m_prev[d][i]) : event_in[i]);
            if (clear) begin
              m_cnt[d][i] = 0; m_ovf[d][i] = 0;
            end else if (counts) begin
              if (m_cnt[d][i] == MAXV) begin
                m_ovf[d][i] = 1;
                m_cnt[d][i] = (d == 1) ? MAXV : 0;
              end else begin
                m_cnt[d][i] = m_cnt[d][i] + 1;
              end
            end
            m_prev[d][i] = event_in[i];
          end
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  task automatic cmp_dut(input int d, input logic [7:0] rdd, input logic rv,
                         input logic re, input logic [3:0] ov, input logic sv);
    logic [3:0] eo;
    for (int i = 0; i < NC; i++) eo[i] = m_ovf[d][i];
    chk($sformatf("dut%0d.rd_data", d),    32'(rdd), 32'(m_rd_data[d]));
    chk($sformatf("dut%0d.rd_valid", d),   32'(rv),  32'(m_rd_valid[d]));
    chk($sformatf("dut%0d.rd_err", d),     32'(re),  32'(m_rd_err[d]));
    chk($sformatf("dut%0d.ovf", d),        32'(ov),  32'(eo));
    chk($sformatf("dut%0d.snap_valid", d), 32'(sv),  32'(m_snapv[d]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp_dut(0, rd_data0, rd_valid0, rd_err0, ovf0, snap_valid0);
        cmp_dut(1, rd_data1, rd_valid1, rd_err1, ovf1, snap_valid1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one read and pin the returned value with literal expectations.
  task automatic read_lit(input string name, input int sel, input logic src,
                          input int exp0, input int exp1);
    rd_req = 1'b1; rd_sel = 4'(sel); rd_src = src;
    @(negedge clk);
    rd_req = 1'b0;
    chk({name, ".valid0"}, 32'(rd_valid0), 32'd1);
    chk({name, ".valid1"}, 32'(rd_valid1), 32'd1);
    chk({name, ".data0"},  32'(rd_data0),  32'(exp0));
    chk({name, ".data1"},  32'(rd_data1),  32'(exp1));
  endtask

  initial begin
    rst = 1'b1; count_en = 1'b0; freeze = 1'b0; clear = 1'b0; snap = 1'b0;
    rd_req = 1'b0; rd_src = 1'b0; event_in = '0; rd_sel = '0;
    run(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset.rd_data0", 32'(rd_data0), 32'd0);
    chk("reset.ovf1",     32'(ovf1),     32'd0);
    chk("reset.snapv0",   32'(snap_valid0), 32'd0);

    // Level counting on the total-cycles channel.
    event_in = 4'b0001; count_en = 1'b1;
    run(10);
    event_in = '0;
    read_lit("level.ch0", CH_TOTAL, RD_LIVE, 10, 10);
    read_lit("level.ch1", CH_BUBBLE, RD_LIVE, 0, 0);
    read_lit("level.ch2", CH_CONDBR, RD_LIVE, 0, 0);
    read_lit("level.ch3", CH_UNCONDBR, RD_LIVE, 0, 0);

    // Edge vs level on the same waveform: high 5, low 2, high 3.
    clear = 1'b1; run(1); clear = 1'b0;
    event_in = 4'b0110; run(5);
    event_in = 4'b0000; run(2);
    event_in = 4'b0110; run(3);
    event_in = '0;
    read_lit("edge.ch1",  CH_BUBBLE, RD_LIVE, 2, 2);
    read_lit("level.ch2", CH_CONDBR, RD_LIVE, 8, 8);

    // Gating: edge arrives while disabled/frozen, released with event still high.
    event_in = 4'b0011; count_en = 1'b0; run(3);
    count_en = 1'b1; freeze = 1'b1;       run(3);
    freeze = 1'b0;                        run(2);
    event_in = '0;
    read_lit("gate.ch0", CH_TOTAL,  RD_LIVE, 2, 2);
    read_lit("gate.ch1", CH_BUBBLE, RD_LIVE, 2, 2);

    // Overflow at WIDTH=8: wrap vs saturate, then clear.
    clear = 1'b1; run(1); clear = 1'b0;
    event_in = 4'b0001; run(256);
    event_in = '0;
    read_lit("ovf.ch0", CH_TOTAL, RD_LIVE, 0, 255);
    chk("ovf.flag0", 32'(ovf0[0]), 32'd1);
    chk("ovf.flag1", 32'(ovf1[0]), 32'd1);
    clear = 1'b1; run(1); clear = 1'b0;
    read_lit("ovf.cleared", CH_TOTAL, RD_LIVE, 0, 0);
    chk("ovf.cleared0", 32'(ovf0), 32'd0);
    chk("ovf.cleared1", 32'(ovf1), 32'd0);

    // Atomic read-and-clear with the channel still incrementing.
    event_in = 4'b0100; run(37);
    snap = 1'b1; clear = 1'b1; rd_req = 1'b1; rd_sel = 4'(CH_CONDBR); rd_src = RD_LIVE;
    @(negedge clk);
    snap = 1'b0; clear = 1'b0; rd_req = 1'b0; event_in = '0;
    chk("rac.preclear0", 32'(rd_data0), 32'd37);
    chk("rac.preclear1", 32'(rd_data1), 32'd37);
    chk("rac.snapv0", 32'(snap_valid0), 32'd1);
    read_lit("rac.live", CH_CONDBR, RD_LIVE, 0, 0);
    read_lit("rac.snap", CH_CONDBR, RD_SNAP, 37, 37);

    // Out-of-range selector.
    rd_req = 1'b1; rd_sel = 4'd5; rd_src = RD_LIVE;
    @(negedge clk);
    rd_req = 1'b0;
    chk("err.rd_err0",   32'(rd_err0),   32'd1);
    chk("err.rd_valid0", 32'(rd_valid0), 32'd0);
    chk("err.rd_data0",  32'(rd_data0),  32'd0);
    chk("err.rd_err1",   32'(rd_err1),   32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 249) == 0);
      count_en = ($urandom_range(0, 7) != 0);
      freeze   = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      snap     = ($urandom_range(0, 19) == 0);
      event_in = 4'($urandom);
      rd_req   = $urandom_range(0, 1) == 1;
      rd_sel   = 4'($urandom_range(0, 7));
      rd_src   = $urandom_range(0, 1) == 1;
      run(1);
    end

    // Reset in the middle of counting.
    rst = 1'b0; clear = 1'b0; snap = 1'b0; freeze = 1'b0; rd_req = 1'b0;
    count_en = 1'b1; event_in = 4'hF;
    run(5);
    rst = 1'b1;
    run(1);
    rst = 1'b0; event_in = '0;
    chk("rst.rd_data0",  32'(rd_data0),  32'd0);
    chk("rst.rd_valid1", 32'(rd_valid1), 32'd0);
    chk("rst.ovf0",      32'(ovf0),      32'd0);
    chk("rst.snapv1",    32'(snap_valid1), 32'd0);
    read_lit("rst.ch0", CH_TOTAL, RD_LIVE, 0, 0);

    run(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
Parametrised performance-counter bank for the pipelined CPU. It generalises the fixed four counters (total cycles, bubbles, conditional branches, unconditional branches) to N_CH channels of configurable width. It adds edge/level event qualification, selectable saturate or wrap overflow, sticky overflow flags, a snapshot/read-and-clear mechanism and a registered read port. It sits beside the CPU core. Event inputs come from the pipeline control signals; the read port is polled by the LED/debug display logic.

Parameters:
N_CH, 4, number of counter channels (1..16)
WIDTH, 32, counter width in bits (8..32)
EDGE_MASK, 0, N_CH-bit mask; bit i=1 makes channel i count rising edges, bit i=0 makes it count high cycles
SATURATE, 0, 1: a counter holds at all-ones on overflow; 0: it wraps to 0
SEL_W, 4, width of rd_sel; must satisfy 2**SEL_W >= N_CH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
count_en  in  1  global count enable (CPU running: go | ~HALT)
freeze  in  1  holds all counters when high; edge history still updates
event_in  in  N_CH  per-channel event strobes, e.g. {uncon_if, con_if, bubble, 1'b1}
clear  in  1  zeroes all live counters and overflow flags
snap  in  1  copies all live counters into snapshot registers
rd_req  in  1  one-cycle read request
rd_sel  in  SEL_W  channel index to read
rd_src  in  1  0 = read live counter, 1 = read snapshot
rd_data  out  WIDTH  read data, registered
rd_valid  out  1  one-cycle pulse qualifying rd_data
rd_err  out  1  one-cycle pulse: rd_sel >= N_CH
ovf  out  N_CH  sticky per-channel overflow flags
snap_valid  out  1  high once at least one snapshot has been taken

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- On rst, all of these clear to 0: counters, snapshots, edge history ev_d, ovf, rd_data, rd_valid, rd_err, snap_valid.
- Event qualification: qual[i] = EDGE_MASK[i] ? (event_in[i] & ~ev_d[i]) : event_in[i].
- ev_d <= event_in every cycle that rst is low, regardless of freeze, count_en or clear.
- Increment condition: inc[i] = count_en & ~freeze & qual[i]. A qualifying channel counts +1 per cycle, never more.
- Overflow when cnt[i] is all-ones and inc[i] is high:
  - SATURATE=1: cnt[i] holds at all-ones and ovf[i] <= 1.
  - SATURATE=0: cnt[i] <= 0 and ovf[i] <= 1.
  - ovf[i] stays set until clear or rst.
- Priority in one cycle, highest first: rst > clear > increment.
  - clear with inc high: cnt becomes 0, not 1, and ovf becomes 0 even if that cycle would overflow.
- snap: snap_reg[i] <= cnt[i], the value before this edge's update.
  - snap and clear in the same cycle is an atomic read-and-clear: the snapshot holds the pre-clear values and the live counters become 0.
  - snap_valid <= 1 on any snap and clears only on rst.
- Read port, latency 1:
  - On rd_req, the next cycle gives rd_valid=1 and rd_data = (rd_src ? snap_reg : cnt)[rd_sel], sampled as the pre-update value at the request edge.
  - If rd_sel >= N_CH: the next cycle gives rd_err=1, rd_valid=0, rd_data=0.
  - Without rd_req: rd_valid and rd_err are 0 and rd_data holds its last value.
  - Back-to-back rd_req every cycle is supported, with one result per cycle.
- A read in the same cycle as clear returns the pre-clear value.
- No state machine beyond these registers; the block is fully pipelined.

Decomposition:
- Shared package cpu_perf_pkg holds:
  - channel index constants CH_TOTAL=0, CH_BUBBLE=1, CH_CONDBR=2, CH_UNCONDBR=3;
  - default WIDTH;
  - the rd_src encodings RD_LIVE and RD_SNAP.
- One sub-module, perf_counter_ch, covers a single channel: edge qualification, counter, overflow flag and snapshot register. It is instantiated N_CH times under generate. The top level holds the read mux and output registers.

Test Plan:
- Level count: N_CH=4, EDGE_MASK=0; hold event_in=4'b0001 and count_en=1 for 10 cycles, then rd_req with rd_sel=0 and rd_src=0 -> next cycle rd_valid=1, rd_data=10; channels 1..3 read 0.
- Edge mode: EDGE_MASK=4'b0010; drive event_in[1] high for 5 cycles, low for 2, high for 3 -> channel 1 reads 2. The same stimulus on a level channel reads 8.
- Gating: count_en=0 or freeze=1 during 6 active event cycles -> counts unchanged. Releasing freeze while event_in stays high must not create an extra edge count.
- Overflow at WIDTH=8: drive 256 events -> with SATURATE=0, cnt=0 and ovf[0]=1; with SATURATE=1, cnt=255 and ovf[0]=1. Then clear -> cnt=0 and ovf=0.
- Read-and-clear: with cnt[2]=37 and inc[2] high, assert snap and clear together -> snapshot reads 37, live count reads 0 next cycle, snap_valid=1.
- Errors and reset: rd_req with rd_sel=5 at N_CH=4 -> rd_err pulse, rd_data=0. Assert rst mid-count -> every output is 0 the next cycle.
